kbd_host_tx: RTL and testbench
==============================

// Module: kbd_host_tx
// PURPOSE
//  PS/2 host-to-device transmitter. Sends one command byte to the keyboard,
//  e.g. 0xED set-LEDs or 0xFF reset, using the standard host-request
//  sequence: inhibit clock, request-to-send, 11 device-clocked bits, device ACK.
//  Sits beside the keyboard receiver and shares the open-drain ps2clk/ps2data
//  pads through the two drive-low outputs.
// PARAMETERS
//  INHIBIT_CYCLES  5000    clk cycles ps2clk is held low before RTS (>=100us at 50MHz)
//  TIMEOUT_CYCLES  750000  max clk cycles from clock release to ACK (15ms at 50MHz)
//  FILT_LEN        8       ps2clk sample history length for edge detection
// PORTS
//  clk             in   1  system clock
//  reset           in   1  synchronous, active-high reset
//  ps2clk          in   1  PS/2 clock pad input (asynchronous)
//  ps2data         in   1  PS/2 data pad input (asynchronous)
//  tx_data         in   8  byte to send; sampled on the accepted tx_start
//  tx_start        in   1  1-cycle request; accepted only in IDLE
//  ps2clk_low      out  1  1 = pull ps2clk low, 0 = release (pad is open-drain)
//  ps2data_low     out  1  1 = pull ps2data low, 0 = release
//  busy            out  1  high from the cycle after accept until return to IDLE
//  done            out  1  1-cycle pulse: frame sent and ACK seen
//  err             out  1  1-cycle pulse: no ACK (data high at 11th fall) or timeout
// BEHAVIOUR
//  - Reset (synchronous, active-high): all outputs 0, both lines released,
//    state IDLE, counters cleared. Reset mid-frame aborts and releases the
//    lines at the next clk edge; no done/err pulse is issued.
//  - Edge detect: 2-flop sync, then FILT_LEN-bit history shift; fall = upper
//    half all 1, lower half all 0. Falls are acted on only in SEND/ACK.
//  - Frame latched at accept: {stop=1, par=~^tx_data, tx_data[7:0]}, LSB first.
//  - FSM:
//     IDLE: tx_start -> latch frame, clear counter, go to INHIBIT.
//           tx_start in any other state is ignored.
//     INHIBIT: ps2clk_low=1 for exactly INHIBIT_CYCLES cycles -> RTS.
//     RTS: 1 cycle, ps2clk_low=1 and ps2data_low=1 (start bit) -> SEND.
//     SEND: ps2clk_low=0, ps2data_low held; bitcnt=0, timeout counter runs.
//           On each fall: ps2data_low <= ~frame[bitcnt], bitcnt++.
//           Falls 1-8 = d0..d7, fall 9 = parity, fall 10 = stop (release).
//           After fall 10 -> ACK.
//     ACK: on the next fall sample synced ps2data: 0 -> WAIT_REL; 1 -> err.
//     WAIT_REL: wait synced ps2clk=1 and ps2data=1, then done pulse -> IDLE.
//  - Timeout: counter starts at SEND entry and is cleared only in IDLE. When it
//    reaches TIMEOUT_CYCLES in SEND, ACK or WAIT_REL: err pulse, release both
//    lines, go to IDLE.
//  - err path: 1-cycle err, lines released that cycle, next state IDLE.
//  - done/err never assert together. busy=0 in the done/err cycle. A tx_start
//    in that same cycle is ignored.
//  - Falls caused by our own inhibit are not counted; history is not cleared.
//  - Counters are sized by $clog2 of their parameter and saturate, never wrap.
// STRUCTURE
//  - Shared include ps2_defs.vh: state encodings (IDLE, INHIBIT, RTS, SEND,
//    ACK, WAIT_REL), PS2_FRAME_BITS=11, common command codes (ED, EE, F4, FF).
//  - One sub-module, ps2_clk_filter (sync + FILT_LEN history -> fall,
//    clk_hi), reusable by the receiver. FSM and datapath stay in this file.
// TESTING (sim with INHIBIT_CYCLES=50, TIMEOUT_CYCLES=2000; device BFM)
//  - tx_data=0xED, BFM ACKs -> ps2clk_low high exactly 50 cycles; bits seen at
//    BFM rising edges: 0,1,0,1,1,0,1,1,1, par=1, stop=1; then one done pulse.
//  - tx_data=0x00 -> par=1; tx_data=0x01 -> par=0; BFM confirms odd parity.
//  - BFM leaves data high at 11th clock -> err pulse, no done, lines released.
//  - BFM never clocks after RTS -> err exactly 2000 cycles after SEND entry.
//  - reset asserted after fall 5 -> next cycle ps2clk_low=ps2data_low=0,
//    busy=0, no done/err; new 0xF4 then completes normally.
//  - tx_start pulsed during SEND and in the done cycle -> ignored, exactly one
//    frame sent.

Source files
------------

// File: rtl/kbd_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM state
// encodings, frame geometry, common keyboard command codes and a helper that
// builds the shifted part of a frame.
package kbd_host_tx_pkg;

   // Full frame on the wire: start, 8 data, parity, stop.
   localparam int unsigned PS2_FRAME_BITS = 11;
   // Bits actually shifted by device clocks (the start bit goes out during RTS).
   localparam int unsigned FRAME_REG_BITS = PS2_FRAME_BITS - 1;

   // Common host-to-keyboard command codes.
   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ECHO     = 8'hEE;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_RESET    = 8'hFF;

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StRts,
      StSend,
      StAck,
      StWaitRel
   } state_e;

   // {stop, odd parity, data}; bit 0 is the first bit shifted after the start bit.
   function automatic logic [FRAME_REG_BITS-1:0] build_frame(input logic [7:0] data);
      return {1'b1, ~^data, data};
   endfunction

endpackage

// File: rtl/kbd_host_tx_clk_filter.sv
// PS/2 clock conditioner: two-flop synchroniser followed by a sample history.
// A fall is reported for exactly one cycle when the older half of the history
// is all ones and the newer half all zeros, which rejects short glitches.
module kbd_host_tx_clk_filter #(
   parameter int unsigned FILT_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic ps2clk,
   output logic fall,
   output logic clk_hi
);

   localparam int unsigned Half = FILT_LEN / 2;

   logic [1:0]          sync_q, sync_d;
   logic [FILT_LEN-1:0] hist_q, hist_d;

   // Shift the pad into the synchroniser and the synchronised value into the history.
   always_comb begin
      sync_d = {sync_q[0], ps2clk};
      hist_d = {hist_q[FILT_LEN-2:0], sync_q[1]};
   end

   // Idle bus is high, so reset everything to ones to avoid a spurious fall.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '1;
         hist_q <= '1;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign fall   = (&hist_q[FILT_LEN-1:Half]) & ~(|hist_q[Half-1:0]);
   assign clk_hi = sync_q[1];

endmodule

// File: rtl/kbd_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the clock, issues request-to-send,
// shifts the frame out on device-generated clock falls and checks the device
// ACK. Drives the shared open-drain pads only through the two *_low outputs.
module kbd_host_tx
   import kbd_host_tx_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000,
   parameter int unsigned FILT_LEN       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2clk,
   input  logic       ps2data,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       ps2clk_low,
   output logic       ps2data_low,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
   localparam logic [TmoW-1:0] TmoMax  = TmoW'(TIMEOUT_CYCLES);
   // Bit index shifted on the last data-phase fall (the stop bit).
   localparam logic [3:0]      LastBit = 4'(FRAME_REG_BITS - 1);

   state_e state_q, state_d;

   logic [FRAME_REG_BITS-1:0] frame_q, frame_d;
   logic [3:0]                bitcnt_q, bitcnt_d;
   logic [InhW-1:0]           inh_cnt_q, inh_cnt_d;
   logic [TmoW-1:0]           tmo_cnt_q, tmo_cnt_d;
   logic                      data_low_q, data_low_d;
   logic [1:0]                data_sync_q, data_sync_d;

   logic fall, clk_hi, data_hi;
   logic timed, tmo_hit, nack, err_evt, done_evt;

   kbd_host_tx_clk_filter #(
      .FILT_LEN (FILT_LEN)
   ) u_clk_filter (
      .clk    (clk),
      .reset  (reset),
      .ps2clk (ps2clk),
      .fall   (fall),
      .clk_hi (clk_hi)
   );

   assign data_hi = data_sync_q[1];

   // Timeout only runs once the device owns the clock.
   assign timed    = (state_q == StSend) || (state_q == StAck) || (state_q == StWaitRel);
   assign tmo_hit  = timed && (tmo_cnt_q == TmoMax);
   assign nack     = (state_q == StAck) && fall && data_hi;
   assign err_evt  = tmo_hit || nack;
   assign done_evt = (state_q == StWaitRel) && clk_hi && data_hi && !tmo_hit;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (tx_start) state_d = StInhibit;
         end
         StInhibit: begin
            if (inh_cnt_q == InhLast) state_d = StRts;
         end
         StRts: begin
            state_d = StSend;
         end
         StSend: begin
            if (tmo_hit) begin
               state_d = StIdle;
            end else if (fall && (bitcnt_q == LastBit)) begin
               state_d = StAck;
            end
         end
         StAck: begin
            if (tmo_hit) begin
               state_d = StIdle;
            end else if (fall) begin
               state_d = data_hi ? StIdle : StWaitRel;
            end
         end
         StWaitRel: begin
            if (tmo_hit || done_evt) state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs; everything is forced released and quiet while reset is held.
   always_comb begin
      ps2clk_low  = 1'b0;
      ps2data_low = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      err         = 1'b0;
      if (!reset) begin
         ps2clk_low  = (state_q == StInhibit) || (state_q == StRts);
         // Lines are released in the same cycle a timeout error is flagged.
         ps2data_low = (state_q == StRts) ||
                       ((state_q == StSend) && data_low_q && !tmo_hit);
         done        = done_evt;
         err         = err_evt;
         busy        = (state_q != StIdle) && !done_evt && !err_evt;
      end
   end

   // Datapath registers: frame, counters, data drive and data synchroniser.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_q     <= '0;
         bitcnt_q    <= '0;
         inh_cnt_q   <= '0;
         tmo_cnt_q   <= '0;
         data_low_q  <= 1'b0;
         data_sync_q <= '1;
      end else begin
         frame_q     <= frame_d;
         bitcnt_q    <= bitcnt_d;
         inh_cnt_q   <= inh_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         data_low_q  <= data_low_d;
         data_sync_q <= data_sync_d;
      end
   end

   // Datapath next-state: latch on accept, count inhibit, shift on falls.
   always_comb begin
      frame_d     = frame_q;
      bitcnt_d    = bitcnt_q;
      inh_cnt_d   = inh_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      data_low_d  = data_low_q;
      data_sync_d = {data_sync_q[0], ps2data};

      unique case (state_q)
         StIdle: begin
            tmo_cnt_d  = '0;
            data_low_d = 1'b0;
            if (tx_start) begin
               frame_d   = build_frame(tx_data);
               inh_cnt_d = '0;
               bitcnt_d  = '0;
            end
         end
         StInhibit: begin
            if (inh_cnt_q != InhLast) inh_cnt_d = inh_cnt_q + InhW'(1);
         end
         StRts: begin
            // Start bit: keep data low into SEND until the first fall.
            data_low_d = 1'b1;
            bitcnt_d   = '0;
         end
         StSend: begin
            if (fall && !tmo_hit) begin
               data_low_d = ~frame_q[bitcnt_q];
               bitcnt_d   = bitcnt_q + 4'd1;
            end
         end
         default: begin
         end
      endcase

      // Saturating timeout counter, cleared only in IDLE.
      if (timed && (tmo_cnt_q != TmoMax)) tmo_cnt_d = tmo_cnt_q + TmoW'(1);
   end

endmodule

// File: tb/tb_kbd_host_tx.sv
// Bench for kbd_host_tx: a PS/2 device model clocks the frame out, a queue holds
// the frame expected for each command and is checked when the device has
// captured all bits.
module tb_kbd_host_tx;

   localparam int H = 20;   // device half clock period in system clocks

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       ps2clk_low, ps2data_low, busy, done, err;
   logic       bfm_clk_low, bfm_data_low;
   logic       ps2clk_pad, ps2data_pad;

   int n_checks = 0;
   int n_pass   = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int both_cnt = 0;
   int start_cnt = 0;
   logic busy_prev = 1'b0;

   logic [10:0] exp_q[$];

   assign ps2clk_pad  = ~(ps2clk_low | bfm_clk_low);
   assign ps2data_pad = ~(ps2data_low | bfm_data_low);

   always #5 clk = ~clk;

   kbd_host_tx #(
      .INHIBIT_CYCLES (50),
      .TIMEOUT_CYCLES (2000),
      .FILT_LEN       (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ps2clk      (ps2clk_pad),
      .ps2data     (ps2data_pad),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .ps2clk_low  (ps2clk_low),
      .ps2data_low (ps2data_low),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   // Pulse and frame-start counters.
   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (err) err_cnt <= err_cnt + 1;
      if (done && err) both_cnt <= both_cnt + 1;
      if (busy && !busy_prev) start_cnt <= start_cnt + 1;
      busy_prev <= busy;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
      $fatal(1);
   end

   function automatic logic [10:0] exp_frame(input logic [7:0] d);
      return {1'b1, ~^d, d, 1'b0};
   endfunction

   task automatic send_cmd(input logic [7:0] d);
      @(negedge clk);
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
   endtask

   // Device model: waits for RTS and clock release, then clocks n_clocks pulses.
   task automatic bfm_device(input int n_clocks, input bit do_ack,
                             output logic [10:0] bits, output bit ok);
      int i;
      bits = '1;
      ok   = 1'b1;
      i = 0;
      while (!(ps2clk_low && ps2data_low) && i < 400) begin
         @(negedge clk);
         i++;
      end
      if (i >= 400) ok = 1'b0;
      i = 0;
      while (ps2clk_low && i < 10) begin
         @(negedge clk);
         i++;
      end
      if (ps2clk_low) ok = 1'b0;
      if (ok) begin
         repeat (4) @(negedge clk);
         bits[0] = ps2data_pad;
         for (int k = 1; k <= 10 && k <= n_clocks; k++) begin
            repeat (H) @(negedge clk);
            bfm_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            bfm_clk_low = 1'b0;
            repeat (3) @(negedge clk);
            bits[k] = ps2data_pad;
         end
         if (n_clocks >= 11) begin
            repeat (H - 5) @(negedge clk);
            if (do_ack) bfm_data_low = 1'b1;
            repeat (5) @(negedge clk);
            bfm_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            bfm_clk_low  = 1'b0;
            bfm_data_low = 1'b0;
            repeat (H) @(negedge clk);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ps2clk_low !== 1'b0) $display("FAIL reset_clk_low: got %b, required 0", ps2clk_low);
      else n_pass++;
      n_checks++;
      if (ps2data_low !== 1'b0) $display("FAIL reset_data_low: got %b, required 0", ps2data_low);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy);
      else n_pass++;
      n_checks++;
      if (done !== 1'b0) $display("FAIL reset_done: got %b, required 0", done);
      else n_pass++;
      n_checks++;
      if (err !== 1'b0) $display("FAIL reset_err: got %b, required 0", err);
      else n_pass++;
   endtask

   task automatic test_led_cmd();
      logic [10:0] bits, exp;
      bit ok;
      int inh, d0;
      d0 = done_cnt;
      exp_q.push_back(exp_frame(8'hED));
      send_cmd(8'hED);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL led_busy: got %b, required 1", busy);
      else n_pass++;
      fork
         begin
            inh = 0;
            while (ps2clk_low && !ps2data_low && inh < 1000) begin
               inh++;
               @(negedge clk);
            end
            n_checks++;
            if (inh !== 50) $display("FAIL led_inhibit_len: got %0d, required 50", inh);
            else n_pass++;
            n_checks++;
            if ({ps2clk_low, ps2data_low} !== 2'b11)
               $display("FAIL led_rts: got %b, required 11", {ps2clk_low, ps2data_low});
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (ps2clk_low !== 1'b0) $display("FAIL led_rts_len: got %b, required 0", ps2clk_low);
            else n_pass++;
         end
         bfm_device(11, 1'b1, bits, ok);
      join
      exp = exp_q.pop_front();
      n_checks++;
      if (ok !== 1'b1) $display("FAIL led_bfm_handshake: got %b, required 1", ok);
      else n_pass++;
      n_checks++;
      if (bits !== exp) $display("FAIL led_frame: got %b, required %b", bits, exp);
      else n_pass++;
      n_checks++;
      if (done_cnt - d0 !== 1) $display("FAIL led_done: got %0d, required 1", done_cnt - d0);
      else n_pass++;
   endtask

   task automatic test_parity();
      logic [10:0] bits, exp;
      bit ok;
      logic [7:0] pats [2];
      pats[0] = 8'h00;
      pats[1] = 8'h01;
      for (int p = 0; p < 2; p++) begin
         exp_q.push_back(exp_frame(pats[p]));
         send_cmd(pats[p]);
         bfm_device(11, 1'b1, bits, ok);
         exp = exp_q.pop_front();
         n_checks++;
         if (bits !== exp) $display("FAIL parity_frame_%02h: got %b, required %b", pats[p], bits, exp);
         else n_pass++;
         n_checks++;
         if ((^bits[9:1]) !== 1'b1)
            $display("FAIL parity_odd_%02h: got %b, required 1", pats[p], ^bits[9:1]);
         else n_pass++;
      end
   endtask

   task automatic test_no_ack();
      logic [10:0] bits, exp;
      bit ok;
      int d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      exp_q.push_back(exp_frame(8'hEE));
      send_cmd(8'hEE);
      bfm_device(11, 1'b0, bits, ok);
      exp = exp_q.pop_front();
      n_checks++;
      if (bits !== exp) $display("FAIL noack_frame: got %b, required %b", bits, exp);
      else n_pass++;
      n_checks++;
      if (err_cnt - e0 !== 1) $display("FAIL noack_err: got %0d, required 1", err_cnt - e0);
      else n_pass++;
      n_checks++;
      if (done_cnt - d0 !== 0) $display("FAIL noack_done: got %0d, required 0", done_cnt - d0);
      else n_pass++;
      n_checks++;
      if ({ps2clk_low, ps2data_low, busy} !== 3'b000)
         $display("FAIL noack_released: got %b, required 000", {ps2clk_low, ps2data_low, busy});
      else n_pass++;
   endtask

   task automatic test_timeout();
      int i, cnt;
      send_cmd(8'hFF);
      i = 0;
      while (ps2clk_low && i < 200) begin
         @(negedge clk);
         i++;
      end
      cnt = 0;
      while (!err && cnt < 3000) begin
         @(negedge clk);
         cnt++;
      end
      n_checks++;
      if (cnt !== 2000) $display("FAIL timeout_cycles: got %0d, required 2000", cnt);
      else n_pass++;
      n_checks++;
      if ({ps2clk_low, ps2data_low, busy} !== 3'b000)
         $display("FAIL timeout_released: got %b, required 000", {ps2clk_low, ps2data_low, busy});
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_frame();
      logic [10:0] bits, exp;
      bit ok;
      int d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      send_cmd(8'hEE);
      bfm_device(5, 1'b0, bits, ok);
      n_checks++;
      if (ps2data_low !== 1'b1) $display("FAIL midreset_driving: got %b, required 1", ps2data_low);
      else n_pass++;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({ps2clk_low, ps2data_low, busy} !== 3'b000)
         $display("FAIL midreset_released: got %b, required 000", {ps2clk_low, ps2data_low, busy});
      else n_pass++;
      n_checks++;
      if ((done_cnt - d0) + (err_cnt - e0) !== 0)
         $display("FAIL midreset_pulses: got %0d, required 0", (done_cnt - d0) + (err_cnt - e0));
      else n_pass++;
      d0 = done_cnt;
      exp_q.push_back(exp_frame(8'hF4));
      send_cmd(8'hF4);
      bfm_device(11, 1'b1, bits, ok);
      exp = exp_q.pop_front();
      n_checks++;
      if (bits !== exp) $display("FAIL midreset_f4_frame: got %b, required %b", bits, exp);
      else n_pass++;
      n_checks++;
      if (done_cnt - d0 !== 1) $display("FAIL midreset_f4_done: got %0d, required 1", done_cnt - d0);
      else n_pass++;
   endtask

   task automatic test_ignore_start();
      logic [10:0] bits, exp;
      bit ok;
      int d0, s0;
      d0 = done_cnt;
      s0 = start_cnt;
      exp_q.push_back(exp_frame(8'hEE));
      send_cmd(8'hEE);
      fork
         bfm_device(11, 1'b1, bits, ok);
         begin
            for (int i = 0; i < 200 && ps2clk_low; i++) @(negedge clk);
            repeat (30) @(negedge clk);
            tx_data  = 8'h55;
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
            for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
         end
      join
      repeat (100) @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++;
      if (bits !== exp) $display("FAIL ignore_frame: got %b, required %b", bits, exp);
      else n_pass++;
      n_checks++;
      if (start_cnt - s0 !== 1) $display("FAIL ignore_frames_started: got %0d, required 1", start_cnt - s0);
      else n_pass++;
      n_checks++;
      if (done_cnt - d0 !== 1) $display("FAIL ignore_done: got %0d, required 1", done_cnt - d0);
      else n_pass++;
      n_checks++;
      if (both_cnt !== 0) $display("FAIL done_err_overlap: got %0d, required 0", both_cnt);
      else n_pass++;
   endtask

   initial begin
      reset        = 1'b1;
      tx_start     = 1'b0;
      tx_data      = 8'h00;
      bfm_clk_low  = 1'b0;
      bfm_data_low = 1'b0;
      test_reset();
      test_led_cmd();
      test_parity();
      test_no_ack();
      test_timeout();
      test_reset_mid_frame();
      test_ignore_start();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
